// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Used by bin2bcd_seq and bcd_digit_adj.
package bin2bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Smallest digit count whose decimal range covers every value below 2**width.
    function automatic int min_digits(input int width);
        longint max_val;
        longint pow10;
        int     d;
        max_val = (longint'(1) << width) - 1;
        pow10   = 1;
        d       = 0;
        while (pow10 <= max_val) begin
            pow10 = pow10 * 10;
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// One BCD digit of the add-3 correction: digits of 5 or more get +3 so that
// the following left shift carries correctly into the next decimal place.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    always_comb begin
        q = (d >= 4'd5) ? d + 4'd3 : d;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift/add-3 binary-to-BCD converter, one operand bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement and report the sign.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          sign
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef BIN2BCD_SIGNED_EN
    localparam int MIN_DIGITS = min_digits(WIDTH - 1);
`else
    localparam int MIN_DIGITS = min_digits(WIDTH);
`endif

    if (WIDTH < 4) begin : g_width_chk
        $error("bin2bcd_seq: WIDTH must be at least 4");
    end
    if (DIGITS < MIN_DIGITS) begin : g_digits_chk
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // in_ready is high only in IDLE, out_valid only in DONE, and bcd/sign
    // stay stable while out_valid is high and out_ready is low.
    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   operand;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_nxt;
    logic [ACC_W-1:0]   bcd_q;
    logic               accept;
    logic               last_shift;
    logic               unused_top;

    assign accept     = in_valid && in_ready;
    assign last_shift = (state == SHIFT) && (count == CNT_W'(1));

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (acc[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (acc_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The top accumulator bit is always zero when DIGITS is legal.
    assign acc_nxt    = {acc_adj[ACC_W-2:0], shreg[WIDTH-1]};
    assign unused_top = acc_adj[ACC_W-1];

`ifdef BIN2BCD_SIGNED_EN
    logic sign_pend;
    logic sign_q;

    // Negating -2**(WIDTH-1) yields the same bit pattern, which is the correct unsigned magnitude.
    assign operand = bin[WIDTH-1] ? -bin : bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_pend <= 1'b0;
            sign_q    <= 1'b0;
        end else begin
            if (accept)
                sign_pend <= bin[WIDTH-1];
            if (last_shift)
                sign_q <= sign_pend;
        end
    end

    assign sign = sign_q;
`else
    assign operand = bin;
    assign sign    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            shreg <= '0;
            acc   <= '0;
            bcd_q <= '0;
        end else if (accept) begin
            count <= CNT_W'(WIDTH);
            shreg <= operand;
            acc   <= '0;
        end else if (state == SHIFT) begin
            count <= count - CNT_W'(1);
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            acc   <= acc_nxt;
            // Published result changes only when a conversion completes.
            if (last_shift)
                bcd_q <= acc_nxt;
        end
    end

    assign bcd = bcd_q;

endmodule
